move_scheduler: RTL

Sequences snake movement. It converts the latched button direction from the input stage into paced, validated moves. Direction changes are queued in a 2-entry turn buffer, and 180° reversals and duplicates are rejected. A programmable tick counter emits one `step` pulse per move period, and each step applies the oldest queued turn. It sits between the button input stage and the snake body/position logic.

---
 rtl/move_scheduler_if.sv | 15 +
 rtl/move_scheduler.sv | 59 +++++
 2 files changed

// File: rtl/move_scheduler_if.sv
// Button-to-body handshake for the move scheduler: requested direction and pacing in,
// paced step and applied direction out.
interface move_scheduler_if #(
  parameter int TICK_W = 26
);
  logic [3:0]        move_dir;
  logic              run;
  logic [TICK_W-1:0] period;
  logic              step;
  logic [3:0]        head_dir;
  logic [1:0]        pending;

  modport master (output move_dir, run, period, input step, head_dir, pending);
  modport slave  (input move_dir, run, period, output step, head_dir, pending);
endinterface

// File: rtl/move_scheduler.sv
// Paces snake moves: filters one-hot turn requests into a 2-deep FIFO and applies
// the oldest turn on each programmable-period step.
module move_scheduler #(
  parameter int TICK_W = 26
) (
  input logic             clk,
  input logic             rst,
  move_scheduler_if.slave bus
);
  logic [3:0]        prev_dir, head_q, ref_dir, rev_dir;
  logic [1:0][3:0]   tbuf, tbuf_nxt;
  logic [1:0]        pend_q, pend_nxt, keep;
  logic [TICK_W-1:0] cnt;
  logic [TICK_W:0]   cnt_inc;
  logic              step_q, req, terminal, pop, accept;

  always_comb begin
    req      = $onehot(bus.move_dir) && (bus.move_dir != prev_dir);
    cnt_inc  = {1'b0, cnt} + {{TICK_W{1'b0}}, 1'b1};
    terminal = bus.run && (cnt_inc >= {1'b0, bus.period});
    pop      = terminal && (pend_q != 2'd0);
    // Turns are judged against where the snake will be heading once the queue drains.
    ref_dir  = (pend_q == 2'd2) ? tbuf[1] : (pend_q == 2'd1) ? tbuf[0] : head_q;
    rev_dir  = {ref_dir[0], ref_dir[1], ref_dir[2], ref_dir[3]};
    keep     = pend_q - {1'b0, pop};
    accept   = req && (bus.move_dir != ref_dir) && (bus.move_dir != rev_dir) && (keep != 2'd2);

    tbuf_nxt = tbuf;
    pend_nxt = keep;
    if (pop) tbuf_nxt[0] = tbuf[1];
    // Pop happens first, so a full buffer has room for a push on a step edge.
    if (accept) begin
      tbuf_nxt[keep[0]] = bus.move_dir;
      pend_nxt          = keep + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_dir <= 4'b0000;
      head_q   <= 4'b0001;
      tbuf     <= '0;
      pend_q   <= 2'd0;
      cnt      <= '0;
      step_q   <= 1'b0;
    end else begin
      prev_dir <= bus.move_dir;
      step_q   <= terminal;
      tbuf     <= tbuf_nxt;
      pend_q   <= pend_nxt;
      if (pop) head_q <= tbuf[0];
      if (bus.run) cnt <= terminal ? '0 : cnt_inc[TICK_W-1:0];
    end
  end

  assign bus.step     = step_q;
  assign bus.head_dir = head_q;
  assign bus.pending  = pend_q;
endmodule
